// File: rtl/intdiv_pkg.sv
// rtl/intdiv_pkg.sv - shared types and derived constants for the sequential integer-division preprocessor
package intdiv_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, CALC, DONE} state_t;

    typedef struct packed {
        logic altb;
        logic bzero;
        logic as;
        logic bs;
        logic w64;
    } flags_t;

    function automatic int scan_count(input int xlen, input int scanw);
        return xlen / scanw;
    endfunction

    function automatic int scan_cntw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int XLEN_DEF      = 64;
    localparam int SCANW_DEF     = 16;
    localparam int SCAN_N        = scan_count(XLEN_DEF, SCANW_DEF);
    localparam int SCAN_CNTW     = scan_cntw(SCAN_N);

endpackage

// File: rtl/lzc.sv
// rtl/lzc.sv - combinational leading-zero counter; an all-zero input counts as WIDTH
module lzc #(
    parameter int WIDTH = 16,
    parameter int ZW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] num,
    output logic [ZW-1:0]    zerocnt
);

    always_comb begin
        zerocnt = ZW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (num[i]) zerocnt = ZW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/lzc_chunk_acc.sv
// rtl/lzc_chunk_acc.sv - serial leading-zero accumulator fed one operand chunk per cycle, MSB chunk first
module lzc_chunk_acc #(
    parameter int SCANW = 16,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic [SCANW-1:0] chunk,
    output logic [CW-1:0]    count
);

    localparam int ZW = $clog2(SCANW + 1);

    logic [ZW-1:0] chunk_zc;
    logic          found;

    lzc #(.WIDTH(SCANW)) u_lzc (
        .num     (chunk),
        .zerocnt (chunk_zc)
    );

    // Once a nonzero chunk is seen the count is frozen; lower chunks cannot add zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            found <= 1'b0;
        end else if (clear) begin
            count <= '0;
            found <= 1'b0;
        end else if (en && !found) begin
            count <= count + CW'(chunk_zc);
            if (chunk != '0) found <= 1'b1;
        end
    end

endmodule

// File: rtl/intdiv_preproc_seq.sv
// rtl/intdiv_preproc_seq.sv - handshaked integer-division preprocessor with serial LZC scan
// Optional IDIVPRE_W64_EN builds the 32-bit-on-RV64 operand adjustment (XLEN=64 only).
module intdiv_preproc_seq
    import intdiv_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int DIVb    = 64,
    parameter int INTDIVb = 64,
    parameter int LOGR    = 1,
    parameter int RK      = 2,
    parameter int SCANW   = SCANW_DEF,
    parameter int DURLEN  = 7,
    parameter int DIVBLEN = $clog2(DIVb + 1) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    SrcA,
    input  logic [XLEN-1:0]    SrcB,
    input  logic [2:0]         Funct3,
    input  logic               W64,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIVb+3:0]    X,
    output logic [DIVb+3:0]    D,
    output logic [DURLEN-1:0]  Cycles,
    output logic [DIVBLEN-1:0] IntNormShift,
    output logic               ISpecialCase,
    output logic               ALTB,
    output logic               BZero,
    output logic               As,
    output logic               Bs,
    output logic               W64Out,
    output logic [XLEN-1:0]    AOut
);

    localparam int NSCAN = scan_count(XLEN, SCANW);
    localparam int CNTW  = scan_cntw(NSCAN);

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic [XLEN-1:0]   posa, posb, ae_q;
    logic              a_s, b_s, b_zero, w64_q, remop;
    flags_t            oflags;

    logic              w64_act;
    logic              signed_div;
    logic [XLEN-1:0]   ae_d, be_d;
    logic              as_d, bs_d;

`ifdef IDIVPRE_W64_EN
    if (XLEN == 64) begin : g_w64
        assign w64_act = W64;
    end else begin : g_no_w64
        assign w64_act = 1'b0;
    end
    logic unused_bits;
    assign unused_bits = Funct3[2];
`else
    assign w64_act = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{Funct3[2], W64};
`endif

    always_comb begin
        signed_div = ~Funct3[0];
        ae_d = w64_act ? {{(XLEN-32){SrcA[31] & signed_div}}, SrcA[31:0]} : SrcA;
        be_d = w64_act ? {{(XLEN-32){SrcB[31] & signed_div}}, SrcB[31:0]} : SrcB;
        as_d = ae_d[XLEN-1] & signed_div;
        bs_d = be_d[XLEN-1] & signed_div;
    end

    logic [SCANW-1:0] chunk_a, chunk_b;

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int k = 0; k < NSCAN; k++) begin
            if (cnt == CNTW'(k)) begin
                chunk_a = posa[XLEN-1-k*SCANW -: SCANW];
                chunk_b = posb[XLEN-1-k*SCANW -: SCANW];
            end
        end
    end

    logic               acc_clear, acc_en;
    logic [DIVBLEN-1:0] ell, m;

    assign acc_clear = (state == IDLE) && in_valid && !flush;
    assign acc_en    = (state == SCAN) && !flush;

    lzc_chunk_acc #(.SCANW(SCANW), .CW(DIVBLEN)) u_acc_a (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (acc_clear),
        .en      (acc_en),
        .chunk   (chunk_a),
        .count   (ell)
    );

    lzc_chunk_acc #(.SCANW(SCANW), .CW(DIVBLEN)) u_acc_b (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (acc_clear),
        .en      (acc_en),
        .chunk   (chunk_b),
        .count   (m)
    );

    logic [DIVb:0]       xnorm, dnorm;
    logic [DIVBLEN-1:0]  zero_diff, p, irb, rsx, ins_d;
    logic [DURLEN-1:0]   cyc_d;
    logic                altb_d, spec_d;
    logic [DIVb+3:0]     x_d;

    always_comb begin
        xnorm     = ((DIVb+1)'(posa) << (DIVb - XLEN + 1)) << ell;
        dnorm     = ((DIVb+1)'(posb) << (DIVb - XLEN + 1)) << m;
        zero_diff = m - ell;
        altb_d    = zero_diff[DIVBLEN-1];
        p         = altb_d ? '0 : zero_diff;
        irb       = DIVBLEN'(LOGR) + p;
        spec_d    = b_zero | altb_d;
        cyc_d     = spec_d ? '0 : DURLEN'((irb + DIVBLEN'(RK - 1)) / DIVBLEN'(RK));
        ins_d     = remop ? m + DIVBLEN'(INTDIVb - (XLEN - 1))
                          : DIVBLEN'(INTDIVb) - (DIVBLEN'(cyc_d) * DIVBLEN'(RK) - DIVBLEN'(LOGR));
        x_d       = {3'b000, xnorm} >> rsx;
    end

    // Aligns the dividend so the first iteration retires a full RK-bit digit.
    if (RK == 1) begin : g_rk1
        assign rsx = '0;
    end else begin : g_rkn
        assign rsx = DIVBLEN'(RK - 1) - ((irb - DIVBLEN'(1)) % DIVBLEN'(RK));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            posa         <= '0;
            posb         <= '0;
            ae_q         <= '0;
            a_s          <= 1'b0;
            b_s          <= 1'b0;
            b_zero       <= 1'b0;
            w64_q        <= 1'b0;
            remop        <= 1'b0;
            oflags       <= '0;
            X            <= '0;
            D            <= '0;
            Cycles       <= '0;
            IntNormShift <= '0;
            ISpecialCase <= 1'b0;
            AOut         <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    posa   <= as_d ? -ae_d : ae_d;
                    posb   <= bs_d ? -be_d : be_d;
                    ae_q   <= ae_d;
                    a_s    <= as_d;
                    b_s    <= bs_d;
                    b_zero <= (be_d == '0);
                    w64_q  <= w64_act;
                    remop  <= Funct3[1];
                    cnt    <= '0;
                    state  <= SCAN;
                end
                SCAN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNTW'(NSCAN - 1)) state <= CALC;
                end
                CALC: begin
                    X            <= x_d;
                    D            <= {3'b000, dnorm};
                    Cycles       <= cyc_d;
                    IntNormShift <= ins_d;
                    ISpecialCase <= spec_d;
                    AOut         <= ae_q;
                    oflags       <= '{altb: altb_d, bzero: b_zero, as: a_s, bs: b_s, w64: w64_q};
                    state        <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign ALTB      = oflags.altb;
    assign BZero     = oflags.bzero;
    assign As        = oflags.as;
    assign Bs        = oflags.bs;
    assign W64Out    = oflags.w64;

endmodule

// File: tb/tb_intdiv_preproc_seq.sv
// tb/tb_intdiv_preproc_seq.sv - randomized self-checking bench for intdiv_preproc_seq against an arithmetic reference
module tb_intdiv_preproc_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] SrcA = '0, SrcB = '0;
    logic [2:0]  Funct3 = '0;
    logic        W64 = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [67:0] X, D;
    logic [6:0]  Cycles;
    logic [7:0]  IntNormShift;
    logic        ISpecialCase, ALTB, BZero, As, Bs, W64Out;
    logic [63:0] AOut;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    intdiv_preproc_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .Funct3       (Funct3),
        .W64          (W64),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .X            (X),
        .D            (D),
        .Cycles       (Cycles),
        .IntNormShift (IntNormShift),
        .ISpecialCase (ISpecialCase),
        .ALTB         (ALTB),
        .BZero        (BZero),
        .As           (As),
        .Bs           (Bs),
        .W64Out       (W64Out),
        .AOut         (AOut)
    );

    typedef struct packed {
        logic [67:0] x;
        logic [67:0] d;
        logic [6:0]  cyc;
        logic [7:0]  ins;
        logic        spec;
        logic        altb;
        logic        bzero;
        logic        sa;
        logic        sb;
        logic        w64o;
        logic [63:0] aout;
    } res_t;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clz64(input logic [63:0] v);
        for (int i = 63; i >= 0; i--) if (v[i]) return 63 - i;
        return 64;
    endfunction

    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [2:0] f3, input logic w);
        res_t r;
        logic sdiv, w_en;
        logic [63:0] ae, be, pa, pb;
        int ell, m, zd, p, irb, cyc, rsx, ins;
        sdiv = ~f3[0];
`ifdef IDIVPRE_W64_EN
        w_en = w;
`else
        w_en = 1'b0 & w;
`endif
        ae = w_en ? {{32{a[31] & sdiv}}, a[31:0]} : a;
        be = w_en ? {{32{b[31] & sdiv}}, b[31:0]} : b;
        r.sa = ae[63] & sdiv;
        r.sb = be[63] & sdiv;
        pa = r.sa ? -ae : ae;
        pb = r.sb ? -be : be;
        ell = clz64(pa);
        m   = clz64(pb);
        zd  = (m - ell) & 255;
        r.altb = (zd >= 128);
        p   = r.altb ? 0 : zd;
        irb = 1 + p;
        cyc = (irb + 1) / 2;
        rsx = 1 - ((irb - 1) % 2);
        r.x = ({4'b0, pa} << (ell + 1)) >> rsx;
        r.d = {4'b0, pb} << (m + 1);
        r.bzero = (be == 64'd0);
        r.spec  = r.bzero | r.altb;
        if (r.spec) cyc = 0;
        ins = f3[1] ? (m + 1) : (64 - (cyc * 2 - 1));
        r.cyc  = 7'(cyc);
        r.ins  = 8'(ins & 255);
        r.w64o = w_en;
        r.aout = ae;
        return r;
    endfunction

    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] f3, input logic w, input int hold);
        res_t e;
        int lat;
        logic [67:0] xs;
        e = model(a, b, f3, w);
        check("in_ready_idle", in_ready, 1'b1);
        SrcA = a; SrcB = b; Funct3 = f3; W64 = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 6);
        check("X", X, e.x);
        check("D", D, e.d);
        check("Cycles", Cycles, e.cyc);
        check("IntNormShift", IntNormShift, e.ins);
        check("ISpecialCase", ISpecialCase, e.spec);
        check("ALTB", ALTB, e.altb);
        check("BZero", BZero, e.bzero);
        check("As", As, e.sa);
        check("Bs", Bs, e.sb);
        check("W64Out", W64Out, e.w64o);
        check("AOut", AOut, e.aout);
        xs = X;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_X", X, xs);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("return_idle", in_ready, 1'b1);
    endtask

    initial begin
        logic [63:0] ra, rb;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_X", X, 68'd0);
        check("rst_AOut", AOut, 64'd0);
        check("rst_flags", {ISpecialCase, ALTB, BZero, As, Bs, W64Out}, 6'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_valid", out_valid, 1'b0);

        do_op(64'd100, 64'd7, 3'b001, 1'b0, 0);
        do_op(-64'sd100, 64'd7, 3'b000, 1'b0, 0);
        do_op(64'h1234, 64'd0, 3'b001, 1'b0, 0);
        do_op(64'd3, 64'd10, 3'b001, 1'b0, 0);
        do_op(64'h0000_0000_8000_0000, 64'd1, 3'b100, 1'b1, 0);
        do_op(64'd100, 64'd7, 3'b011, 1'b0, 0);
        do_op(64'd0, 64'd5, 3'b000, 1'b0, 0);
        do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 1'b0, 0);
        do_op(64'd999, 64'd13, 3'b001, 1'b0, 10);

        // flush during the second SCAN cycle
        check("fl_in_ready", in_ready, 1'b1);
        SrcA = 64'd500; SrcB = 64'd3; Funct3 = 3'b001; W64 = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("fl_no_result", out_valid, 1'b0);

        // reset asserted while in CALC, after a result with nonzero outputs
        do_op(64'd100, 64'd7, 3'b000, 1'b0, 0);
        SrcA = 64'd77; SrcB = 64'd2; Funct3 = 3'b001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rc_X", X, 68'd0);
        check("rc_D", D, 68'd0);
        check("rc_Cycles", Cycles, 7'd0);
        check("rc_IntNormShift", IntNormShift, 8'd0);
        check("rc_AOut", AOut, 64'd0);
        check("rc_out_valid", out_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rc_in_ready", in_ready, 1'b1);

        for (int n = 0; n < 150; n++) begin
            ra = {$urandom, $urandom} >> $urandom_range(0, 63);
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) rb = 64'd0;
            if ($urandom_range(0, 3) == 0) ra = -ra;
            do_op(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
